// File: rtl/bcd_pkg.sv
// Shared widths, FSM state type and digit-validity helper for the BCD-to-binary converter.
package bcd_pkg;

  localparam int unsigned N_DIGITS = 5;
  localparam int unsigned DIG_W    = 4;
  localparam int unsigned BCD_W    = N_DIGITS * DIG_W;
  localparam int unsigned IN_W     = BCD_W + 1;
  localparam int unsigned MAG_W    = 17;
  localparam int unsigned OUT_W    = 16;
  localparam int unsigned ITER     = 17;
  localparam int unsigned LATENCY  = 18;
  localparam int unsigned CNT_W    = 5;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    FIN   = 2'd2
  } state_t;

  // True when any packed digit is outside 0..9.
  function automatic logic digito_invalido(input logic [BCD_W-1:0] b);
    logic inv;
    inv = 1'b0;
    for (int unsigned i = 0; i < N_DIGITS; i++) begin
      if (b[DIG_W*i +: DIG_W] > 4'd9) inv = 1'b1;
    end
    return inv;
  endfunction

endpackage

// File: rtl/ajuste_bcd.sv
// Reverse double-dabble digit correction: digits at or above 8 are reduced by 3.
module ajuste_bcd
  import bcd_pkg::*;
(
  input  logic [DIG_W-1:0] d,
  output logic [DIG_W-1:0] q_c
);

  always_comb begin
    q_c = d;
    if (d >= 4'd8) q_c = d - 4'd3;
  end

endmodule

// File: rtl/bcd_a_binario.sv
// Sequential signed BCD (sign + 5 digits) to 16-bit two's-complement converter,
// one reverse double-dabble step per cycle.
module bcd_a_binario
  import bcd_pkg::*;
(
  input  logic             CLK100MHZ,
  input  logic             reset,
  input  logic             start,
  input  logic [IN_W-1:0]  codigo_BCD,
  output logic [OUT_W-1:0] bin,
  output logic             done,
  output logic             busy,
  output logic             error
);

  localparam logic [MAG_W-1:0] MAX_POS = MAG_W'(32767);
  localparam logic [MAG_W-1:0] MAX_NEG = MAG_W'(32768);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ITER - 1);

  state_t             state_q, state_d;
  logic               signo_q, signo_d;
  logic               inval_q, inval_d;
  logic [BCD_W-1:0]   bcd_q, bcd_d;
  logic [MAG_W-1:0]   mag_q, mag_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [OUT_W-1:0]   bin_d;
  logic               done_d, busy_d, error_d;

  logic [BCD_W-1:0]   bcd_sh_c, bcd_adj_c;
  logic [MAG_W-1:0]   mag_sh_c, mag_neg_c;
  logic               rango_ok_c;

  // One step: shift {bcd, mag} right, then correct every BCD digit.
  assign bcd_sh_c  = {1'b0, bcd_q[BCD_W-1:1]};
  assign mag_sh_c  = {bcd_q[0], mag_q[MAG_W-1:1]};
  assign mag_neg_c = MAG_W'(~mag_sh_c + MAG_W'(1));

  for (genvar g = 0; g < N_DIGITS; g++) begin : g_ajuste
    ajuste_bcd u_ajuste (
      .d   (bcd_sh_c[DIG_W*g +: DIG_W]),
      .q_c (bcd_adj_c[DIG_W*g +: DIG_W])
    );
  end

  // Negative range reaches one further to include -32768.
  assign rango_ok_c = signo_q ? (mag_sh_c <= MAX_NEG) : (mag_sh_c <= MAX_POS);

  always_comb begin
    state_d = state_q;
    signo_d = signo_q;
    inval_d = inval_q;
    bcd_d   = bcd_q;
    mag_d   = mag_q;
    cnt_d   = cnt_q;
    bin_d   = bin;
    error_d = error;
    done_d  = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          signo_d = codigo_BCD[IN_W-1];
          bcd_d   = codigo_BCD[BCD_W-1:0];
          mag_d   = '0;
          cnt_d   = '0;
          inval_d = digito_invalido(codigo_BCD[BCD_W-1:0]);
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        bcd_d = bcd_adj_c;
        mag_d = mag_sh_c;
        cnt_d = cnt_q + CNT_W'(1);
        // Result is registered on the last step so it appears with done in FIN.
        if (cnt_q == CNT_LAST) begin
          state_d = FIN;
          done_d  = 1'b1;
          if (inval_q || !rango_ok_c) begin
            bin_d   = '0;
            error_d = 1'b1;
          end else begin
            bin_d   = signo_q ? mag_neg_c[OUT_W-1:0] : mag_sh_c[OUT_W-1:0];
            error_d = 1'b0;
          end
        end
      end
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge CLK100MHZ or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      signo_q <= 1'b0;
      inval_q <= 1'b0;
      bcd_q   <= '0;
      mag_q   <= '0;
      cnt_q   <= '0;
      bin     <= '0;
      done    <= 1'b0;
      busy    <= 1'b0;
      error   <= 1'b0;
    end else begin
      state_q <= state_d;
      signo_q <= signo_d;
      inval_q <= inval_d;
      bcd_q   <= bcd_d;
      mag_q   <= mag_d;
      cnt_q   <= cnt_d;
      bin     <= bin_d;
      done    <= done_d;
      busy    <= busy_d;
      error   <= error_d;
    end
  end

endmodule

// File: doc/bcd_a_binario.md
BCD_A_BINARIO -- requirements
Module: bcd_a_binario

Interface
REQ-001 Parameters: none; all widths SHALL come from bcd_pkg constants (N_DIGITS=5, MAG_W=17, OUT_W=16).
REQ-002 Clocking SHALL be one clock; reset is asynchronous and active-high.
REQ-003 CLK100MHZ  input  1  system clock; all state changes on rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 start  input  1  request; sampled only in IDLE.
REQ-006 codigo_BCD  input  21  {signo, d4..d0}; bit 20 is sign (1 = negative), d4 is the most significant digit, each digit is 4-bit BCD.
REQ-007 bin  output  16  two's-complement result; holds between conversions.
REQ-008 done  output  1  one-cycle pulse; bin and error are valid in the same cycle.
REQ-009 busy  output  1  high in every state except IDLE.
REQ-010 error  output  1  set with done when the input is invalid or out of range; holds until the next done.

Function
REQ-011 FSM states SHALL be IDLE, SHIFT and FIN; these are the only states.
REQ-012 IDLE with start=1 SHALL:
- latch the sign;
- load the 20 digit bits into the BCD register;
- clear the 17-bit magnitude register and the iteration counter;
- latch the invalid-digit flag (any digit > 9);
- go to SHIFT.
REQ-013 start SHALL be ignored while busy=1; no queuing.
REQ-014 Each SHIFT cycle SHALL perform one reverse double-dabble step:
- shift {BCD register, magnitude register} right one bit;
- then subtract 3 from every digit whose value is >= 8.
REQ-015 SHIFT SHALL run exactly 17 cycles (counter 0..16), then go to FIN; the count SHALL NOT depend on operand value or validity.
REQ-016 In FIN the 17-bit magnitude M SHALL be range-checked:
- positive valid range is M <= 32767;
- negative valid range is M <= 32768.
REQ-017 FIN output for a valid input SHALL be bin = signo ? -M : M, truncated to 16 bits, with error=0.
REQ-018 FIN output for an invalid digit or an out-of-range M SHALL be bin=0 and error=1.
REQ-019 Negative zero (signo=1, all digits 0) SHALL give bin=0 and error=0.
REQ-020 FIN SHALL assert done for one cycle and return to IDLE.
REQ-021 Latency: done SHALL be high in the cycle after the 18th rising edge, counting the edge that sampled start as edge 1.
REQ-022 A new start SHALL be accepted in the IDLE cycle immediately after done; throughput is one conversion per 19 cycles.
REQ-023 codigo_BCD SHALL NOT be sampled after the start edge; later input changes SHALL NOT affect the result.

Reset
REQ-024 Reset SHALL force the following, independent of the clock:
- state=IDLE;
- bin=0, done=0, busy=0, error=0;
- all internal registers cleared.
REQ-025 Reset asserted mid-conversion SHALL abort the conversion; done SHALL NOT pulse for the aborted request.
REQ-026 After reset deasserts, the first rising edge with start=1 in IDLE SHALL begin a normal conversion.

Structure
REQ-027 bcd_pkg SHALL hold:
- the state enum;
- N_DIGITS, MAG_W, OUT_W;
- ITER=17 and LATENCY=18.
REQ-028 Per-digit correction (d >= 8 ? d-3 : d) SHALL be a combinational sub-module, ajuste_bcd, instantiated N_DIGITS times.
REQ-029 bcd_a_binario SHALL be the inverse stage of binario_a_BCD.
REQ-030 For every valid input, bcd_a_binario(binario_a_BCD(x)) SHALL equal x.

Verification
REQ-031 Valid positive: start with codigo_BCD = {0, 1,2,3,4,5} -> 18 cycles later, done=1, bin=16'h3039, error=0.
REQ-032 Range limits:
- {1, 3,2,7,6,8} -> bin=16'h8000, error=0;
- {0, 3,2,7,6,8} -> bin=0, error=1.
REQ-033 Invalid digit: {0, 0,0,0,0,A} -> done after 18 cycles, bin=0, error=1; then {1, 0,0,0,0,7} -> bin=16'hFFF9, error=0.
REQ-034 Reset mid-conversion: start {0, 0,0,2,5,5}, pulse reset at cycle 9 ->
- all outputs 0 immediately;
- no done pulse;
- a following start of {0, 0,0,2,5,5} -> bin=16'h00FF.
REQ-035 Busy and ordering: second start pulses during SHIFT are ignored (exactly one done); a start in the cycle after done is accepted.
REQ-036 Round trip: random 16-bit x through binario_a_BCD, then bcd_a_binario -> x.
